// File: rtl/oam_dma_if.sv
// Bus bundle for the OAM DMA engine: CPU register port, source-read port and OAM write port.
// The DMA side uses the master modport, the system side (bus/memories) uses slave.
interface oam_dma_if;
  logic        ce;
  logic        reg_wr;
  logic [7:0]  reg_d;
  logic [7:0]  reg_q;
  logic [15:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_d;
  logic [6:0]  oam_addr;
  logic [15:0] oam_d;
  logic [1:0]  oam_be;
  logic        oam_we;
  logic        busy;

  modport master (
    input  ce, reg_wr, reg_d, src_d,
    output reg_q, src_addr, src_rd, oam_addr, oam_d, oam_be, oam_we, busy
  );

  modport slave (
    output ce, reg_wr, reg_d, src_d,
    input  reg_q, src_addr, src_rd, oam_addr, oam_d, oam_be, oam_we, busy
  );
endinterface

// File: rtl/oam_dma.sv
// OAM DMA engine: copies XFER_LEN bytes from page XX00 into OAM, one byte per M-cycle,
// with a read stage (p0) feeding a one-byte write buffer (p1) packed into the 16-bit OAM word.
module oam_dma #(
  parameter int XFER_LEN = 160
) (
  input  logic     clk,
  input  logic     rst,
  oam_dma_if.master bus
);

  typedef enum logic [1:0] {IDLE, START, XFER} state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_page;
  logic [7:0] r_idx_p0;
  logic [7:0] r_buf_p1;
  logic [7:0] r_buf_idx_p1;
  logic       r_vld_p1;
  logic [7:0] w_eff_page;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (bus.ce) begin
      r_state <= w_next;
    end
  end

  // A register write restarts from any state, including START (which then lasts one more M-cycle).
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = IDLE;
      START:   w_next = XFER;
      XFER:    if (r_idx_p0 == LAST_IDX) w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (bus.reg_wr) w_next = START;
  end

  // Stage p0: source page / byte index
  always_ff @(posedge clk) begin
    if (rst) begin
      r_page   <= 8'hFF;
      r_idx_p0 <= 8'd0;
    end else if (bus.ce) begin
      if (bus.reg_wr) begin
        r_page   <= bus.reg_d;
        r_idx_p0 <= 8'd0;
      end else if (r_state == XFER) begin
        r_idx_p0 <= r_idx_p0 + 8'd1;
      end
    end
  end

  // Stage p1: captured byte waiting for its OAM write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1 <= 1'b0;
    end else if (bus.ce) begin
      r_vld_p1 <= (r_state == XFER);
    end
  end

  always_ff @(posedge clk) begin
    if (bus.ce && (r_state == XFER)) begin
      r_buf_p1     <= bus.src_d;
      r_buf_idx_p1 <= r_idx_p0;
    end
  end

  // Echo RAM E000-FFFF mirrors C000-DFFF, so bit 5 of the page is dropped there.
  always_comb begin
    w_eff_page   = (r_page >= 8'hE0) ? (r_page & 8'hDF) : r_page;
    bus.reg_q    = r_page;
    bus.src_rd   = (r_state == XFER);
    bus.src_addr = {w_eff_page, r_idx_p0};
    bus.oam_we   = r_vld_p1;
    bus.oam_addr = {r_buf_idx_p1[7:2], ~r_buf_idx_p1[1]};
    bus.oam_be   = r_buf_idx_p1[0] ? 2'b01 : 2'b10;
    bus.oam_d    = {r_buf_p1, r_buf_p1};
    bus.busy     = (r_state != IDLE) | r_vld_p1;
  end

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: steps whole M-cycles, samples outputs before each ce edge.
module tb_oam_dma;

  logic clk = 1'b0;
  logic rst;
  oam_dma_if bus ();

  oam_dma #(.XFER_LEN(160)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ce_div = 1;
  int stab_err = 0;
  bit layout = 1'b0;
  logic [15:0] oam [0:79];

  // Source memory: byte = low address byte, except sprite 5 when layout mode is on.
  always_comb begin
    bus.src_d = bus.src_addr[7:0];
    if (layout) begin
      case (bus.src_addr[7:0])
        8'd20:   bus.src_d = 8'h20;
        8'd21:   bus.src_d = 8'h18;
        8'd22:   bus.src_d = 8'h42;
        8'd23:   bus.src_d = 8'h60;
        default: bus.src_d = bus.src_addr[7:0];
      endcase
    end
  end

  logic        s_busy, s_rd, s_we;
  logic [15:0] s_addr, s_od;
  logic [6:0]  s_oaddr;
  logic [1:0]  s_be;
  logic [7:0]  s_q;

  // One M-cycle: ce_div clocks with ce on the last; outputs snapshotted before the edge.
  task automatic mstep(input logic wr, input logic [7:0] d);
    for (int k = 0; k < ce_div; k++) begin
      bus.ce = (k == ce_div - 1);
      bus.reg_wr = wr;
      bus.reg_d = d;
      #1;
      if (k == 0) begin
        s_busy = bus.busy; s_rd = bus.src_rd; s_we = bus.oam_we; s_addr = bus.src_addr;
        s_od = bus.oam_d; s_oaddr = bus.oam_addr; s_be = bus.oam_be; s_q = bus.reg_q;
      end else if (s_busy !== bus.busy || s_rd !== bus.src_rd || s_we !== bus.oam_we ||
                   s_addr !== bus.src_addr || s_od !== bus.oam_d || s_oaddr !== bus.oam_addr ||
                   s_be !== bus.oam_be || s_q !== bus.reg_q) begin
        stab_err++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.ce = 1'b0;
    bus.reg_wr = 1'b0;
    if (s_we === 1'b1 && s_oaddr < 7'd80) begin
      if (s_be[1]) oam[s_oaddr][15:8] = s_od[15:8];
      if (s_be[0]) oam[s_oaddr][7:0]  = s_od[7:0];
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.ce = 1'b0; bus.reg_wr = 1'b0; bus.reg_d = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.src_rd !== 1'b0) begin errors++; $display("FAIL reset_src_rd got=%b exp=0", bus.src_rd); end
    checks++; if (bus.oam_we !== 1'b0) begin errors++; $display("FAIL reset_oam_we got=%b exp=0", bus.oam_we); end
    checks++; if (bus.reg_q !== 8'hFF) begin errors++; $display("FAIL reset_reg_q got=%h exp=ff", bus.reg_q); end
    @(negedge clk);
  endtask

  task automatic test_basic;
    int busy_cnt, rd_cnt, wr_cnt, wr_err, first_e, k;
    logic [15:0] first_addr;
    logic b0_we, bl_we;
    logic [6:0] b0_a, bl_a;
    logic [1:0] b0_be, bl_be;
    logic [15:0] b0_d, bl_d;
    logic [6:0] ea;
    logic [1:0] eb;
    busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; wr_err = 0; first_e = 0; first_addr = 16'h0;
    mstep(1'b1, 8'hC1);
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL basic_busy_before got=%b exp=0", s_busy); end
    for (int e = 1; e <= 170; e++) begin
      mstep(1'b0, 8'h00);
      if (s_busy === 1'b1) busy_cnt++;
      if (s_rd === 1'b1) begin
        rd_cnt++;
        if (first_e == 0) begin first_e = e; first_addr = s_addr; end
      end
      if (s_we === 1'b1) begin
        wr_cnt++;
        k = e - 3;
        ea = 7'((k / 4) * 2 + (((k % 4) >= 2) ? 0 : 1));
        eb = ((k % 2) == 1) ? 2'b01 : 2'b10;
        if (s_oaddr !== ea || s_be !== eb) wr_err++;
        else if (eb == 2'b10 && s_od[15:8] !== 8'(k)) wr_err++;
        else if (eb == 2'b01 && s_od[7:0] !== 8'(k)) wr_err++;
      end
      if (e == 3) begin b0_we = s_we; b0_a = s_oaddr; b0_be = s_be; b0_d = s_od; end
      if (e == 162) begin bl_we = s_we; bl_a = s_oaddr; bl_be = s_be; bl_d = s_od; end
    end
    checks++; if (first_e != 2) begin errors++; $display("FAIL basic_first_read_edge got=%0d exp=2", first_e); end
    checks++; if (first_addr !== 16'hC100) begin errors++; $display("FAIL basic_first_addr got=%h exp=c100", first_addr); end
    checks++; if (rd_cnt != 160) begin errors++; $display("FAIL basic_reads got=%0d exp=160", rd_cnt); end
    checks++; if (wr_cnt != 160) begin errors++; $display("FAIL basic_writes got=%0d exp=160", wr_cnt); end
    checks++; if (wr_err != 0) begin errors++; $display("FAIL basic_write_packing bad=%0d exp=0", wr_err); end
    checks++; if (busy_cnt != 162) begin errors++; $display("FAIL basic_busy_len got=%0d exp=162", busy_cnt); end
    checks++; if ({b0_we, b0_a, b0_be, b0_d[15:8]} !== {1'b1, 7'd1, 2'b10, 8'h00})
      begin errors++; $display("FAIL basic_byte0 got we=%b a=%0d be=%b d=%h exp we=1 a=1 be=10 d=00xx", b0_we, b0_a, b0_be, b0_d); end
    checks++; if ({bl_we, bl_a, bl_be, bl_d[7:0]} !== {1'b1, 7'd78, 2'b01, 8'h9F})
      begin errors++; $display("FAIL basic_byte159 got we=%b a=%0d be=%b d=%h exp we=1 a=78 be=01 d=xx9f", bl_we, bl_a, bl_be, bl_d); end
    checks++; if (bus.reg_q !== 8'hC1) begin errors++; $display("FAIL basic_reg_q got=%h exp=c1", bus.reg_q); end
  endtask

  task automatic test_layout;
    for (int w = 0; w < 80; w++) oam[w] = 16'h0000;
    layout = 1'b1;
    mstep(1'b1, 8'hC2);
    for (int e = 1; e <= 165; e++) mstep(1'b0, 8'h00);
    layout = 1'b0;
    checks++; if (oam[11] !== 16'h2018) begin errors++; $display("FAIL layout_word11 got=%h exp=2018", oam[11]); end
    checks++; if (oam[10] !== 16'h4260) begin errors++; $display("FAIL layout_word10 got=%h exp=4260", oam[10]); end
    checks++; if (oam[0] !== 16'h0203) begin errors++; $display("FAIL layout_word0 got=%h exp=0203", oam[0]); end
    checks++; if (oam[1] !== 16'h0001) begin errors++; $display("FAIL layout_word1 got=%h exp=0001", oam[1]); end
  endtask

  task automatic test_echo;
    int bad, rd_cnt;
    logic [15:0] first_a, last_a;
    bad = 0; rd_cnt = 0; first_a = 16'h0; last_a = 16'h0;
    mstep(1'b1, 8'hE3);
    for (int e = 1; e <= 165; e++) begin
      mstep(1'b0, 8'h00);
      if (s_rd === 1'b1) begin
        if (rd_cnt == 0) first_a = s_addr;
        last_a = s_addr;
        rd_cnt++;
        if (s_addr < 16'hC300 || s_addr > 16'hC39F) bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL echo_range bad=%0d exp=0", bad); end
    checks++; if (first_a !== 16'hC300 || last_a !== 16'hC39F)
      begin errors++; $display("FAIL echo_bounds got=%h..%h exp=c300..c39f", first_a, last_a); end
    checks++; if (rd_cnt != 160) begin errors++; $display("FAIL echo_reads got=%0d exp=160", rd_cnt); end
    checks++; if (bus.reg_q !== 8'hE3) begin errors++; $display("FAIL echo_reg_q got=%h exp=e3", bus.reg_q); end
  endtask

  task automatic test_restart;
    int low_early, busy_cnt, wr_cnt, first_low;
    logic [15:0] nxt;
    low_early = 0; busy_cnt = 0; wr_cnt = 0; first_low = 0; nxt = 16'h0;
    mstep(1'b1, 8'hC1);
    for (int e = 1; e <= 51; e++) begin
      mstep(1'b0, 8'h00);
      if (s_busy !== 1'b1) low_early++;
    end
    mstep(1'b1, 8'hD0);
    if (s_busy !== 1'b1) low_early++;
    checks++; if ({s_rd, s_addr} !== {1'b1, 16'hC132})
      begin errors++; $display("FAIL restart_read50 got rd=%b a=%h exp rd=1 a=c132", s_rd, s_addr); end
    mstep(1'b0, 8'h00);
    if (s_busy !== 1'b1) low_early++;
    checks++; if ({s_rd, s_we, s_oaddr, s_be, s_od[15:8]} !== {1'b0, 1'b1, 7'd24, 2'b10, 8'h32})
      begin errors++; $display("FAIL restart_start_write got rd=%b we=%b a=%0d be=%b d=%h exp rd=0 we=1 a=24 be=10 d=32xx",
                              s_rd, s_we, s_oaddr, s_be, s_od); end
    for (int j = 1; j <= 170; j++) begin
      mstep(1'b0, 8'h00);
      if (j == 1) nxt = s_rd ? s_addr : 16'hXXXX;
      if (s_busy === 1'b1) busy_cnt++;
      else if (first_low == 0) first_low = j;
      if (s_we === 1'b1) wr_cnt++;
    end
    checks++; if (nxt !== 16'hD000) begin errors++; $display("FAIL restart_next_read got=%h exp=d000", nxt); end
    checks++; if (wr_cnt != 160) begin errors++; $display("FAIL restart_writes got=%0d exp=160", wr_cnt); end
    checks++; if (low_early != 0 || first_low != 162 || busy_cnt != 161)
      begin errors++; $display("FAIL restart_busy early_low=%0d first_low=%0d cnt=%0d exp 0/162/161", low_early, first_low, busy_cnt); end
  endtask

  task automatic test_reset_mid;
    int wr_cnt, rd_cnt;
    wr_cnt = 0; rd_cnt = 0;
    mstep(1'b1, 8'hC1);
    for (int e = 1; e <= 81; e++) mstep(1'b0, 8'h00);
    #1;
    checks++; if ({bus.src_rd, bus.src_addr} !== {1'b1, 16'hC150})
      begin errors++; $display("FAIL rstmid_pre got rd=%b a=%h exp rd=1 a=c150", bus.src_rd, bus.src_addr); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++; if ({bus.src_rd, bus.oam_we, bus.busy} !== 3'b000)
      begin errors++; $display("FAIL rstmid_outputs got rd/we/busy=%b%b%b exp=000", bus.src_rd, bus.oam_we, bus.busy); end
    checks++; if (bus.reg_q !== 8'hFF) begin errors++; $display("FAIL rstmid_reg_q got=%h exp=ff", bus.reg_q); end
    @(negedge clk);
    for (int e = 1; e <= 20; e++) begin
      mstep(1'b0, 8'h00);
      if (s_we !== 1'b0) wr_cnt++;
      if (s_rd !== 1'b0) rd_cnt++;
    end
    checks++; if (wr_cnt != 0 || rd_cnt != 0)
      begin errors++; $display("FAIL rstmid_quiet got writes=%0d reads=%0d exp=0/0", wr_cnt, rd_cnt); end
  endtask

  task automatic test_ce_gating;
    int busy_cnt, wr_cnt;
    logic [7:0] last_lo;
    busy_cnt = 0; wr_cnt = 0; last_lo = 8'h00;
    ce_div = 4;
    stab_err = 0;
    mstep(1'b1, 8'hC1);
    for (int e = 1; e <= 170; e++) begin
      mstep(1'b0, 8'h00);
      if (s_busy === 1'b1) busy_cnt++;
      if (s_we === 1'b1) begin wr_cnt++; last_lo = s_od[7:0]; end
    end
    ce_div = 1;
    checks++; if (busy_cnt != 162) begin errors++; $display("FAIL gate_busy_len got=%0d exp=162", busy_cnt); end
    checks++; if (wr_cnt != 160) begin errors++; $display("FAIL gate_writes got=%0d exp=160", wr_cnt); end
    checks++; if (last_lo !== 8'h9F) begin errors++; $display("FAIL gate_last_byte got=%h exp=9f", last_lo); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL gate_stability unstable=%0d exp=0", stab_err); end
  endtask

  initial begin
    for (int w = 0; w < 80; w++) oam[w] = 16'h0000;
    test_reset();
    test_basic();
    test_layout();
    test_echo();
    test_restart();
    test_reset_mid();
    test_ce_gating();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
# oam_dma

OAM DMA engine for the Game Boy PPU: on a CPU write to the DMA register (FF46), it copies 160 bytes from source page `XX00–XX9F` into OAM. It is the write side of the 16-bit OAM port that the sprite loader reads, and it packs each byte into the OAM word layout that the loader expects. It sits beside the PPU on the CPU memory bus. It raises `busy` while active so the bus arbiter can block CPU access to OAM.

## Interface
Parameters:
- `XFER_LEN`, 160: bytes per transfer (fixed by hardware; parameter exists for test shortening).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  M-cycle enable; all state advances only on `clk` edges with `ce=1` (except reset).
- `reg_wr`  in  1  CPU write strobe to FF46; sampled only when `ce=1`.
- `reg_d`  in  8  CPU write data (source page).
- `reg_q`  out  8  FF46 readback: last written page.
- `src_addr`  out  16  source byte address.
- `src_rd`  out  1  source read request for the current M-cycle.
- `src_d`  in  8  source data, valid at the `ce` edge ending the M-cycle in which `src_rd=1`.
- `oam_addr`  out  7  OAM word address (0–79).
- `oam_d`  out  16  OAM write data.
- `oam_be`  out  2  byte enables: [1]=high byte, [0]=low byte.
- `oam_we`  out  1  OAM write; commits on the `ce` edge ending the M-cycle.
- `busy`  out  1  transfer in progress; CPU OAM access must be blocked.

## Operation
- States: `IDLE`, `START`, `XFER`. There is a separate write stage with byte buffer `buf[7:0]`, `buf_valid` and `buf_idx[7:0]`.
- At a `ce` edge with `reg_wr=1` (any state):
  - `page <= reg_d`, `idx <= 0`, state `<= START`.
  - `reg_q` reflects the new page from the next cycle.
- `START`: exactly one M-cycle with no read. The next `ce` edge moves to `XFER`.
- `XFER`:
  - `src_rd=1`, `src_addr = {eff_page, idx}`.
  - Page folding: `eff_page = page` with bit 5 cleared when `page >= 8'hE0`, so E0–FF folds to C0–DF.
  - At each `ce` edge: `buf <= src_d`, `buf_idx <= idx`, `buf_valid <= 1`, `idx <= idx+1`.
  - When `idx == XFER_LEN-1`, state `<= IDLE` at that edge.
- Write stage:
  - At every `ce` edge, `buf_valid <= (state==XFER) & ~rst`.
  - `oam_we = buf_valid`, combinational from the buffer and held for the whole M-cycle.
- Byte packing, with `i = buf_idx`, `n = i[7:2]`, `f = i[1:0]`:
  - `oam_addr = {n[5:0], ~f[1]}`: y/x go to the odd word, tile/attrs to the even word.
  - `oam_be = f[0] ? 2'b01 : 2'b10`: y and tile in the high byte, x and attrs in the low byte.
  - `oam_d = {buf, buf}`.
- `busy = (state != IDLE) | buf_valid`.
- Restart mid-transfer (`reg_wr` in `XFER`):
  - The byte read during that M-cycle is still captured, and it is written during the following `START` M-cycle.
  - The new transfer then begins from idx 0 with the new page.
- Restart in `START`: the new page replaces the old one and `START` lasts one more M-cycle.
- Outputs when not reading: `src_addr` is `{eff_page, idx}` but is don't-care when `src_rd=0`. `oam_addr`, `oam_d` and `oam_be` are don't-care when `oam_we=0`.
- Reset values:
  - State `IDLE`; `idx=0`; `buf_valid=0`; `page=reg_q=8'hFF`.
  - `src_rd=0`, `oam_we=0`, `busy=0`.
  - Reset mid-transfer aborts immediately and no further writes occur.

## Timing
- Let E0 be the `ce` edge sampling `reg_wr`. The M-cycle after E0 is `START`.
- Reads of bytes 0..159 occur in the M-cycles ending E2..E161.
- The write of byte k occurs in the M-cycle ending E(k+3); the last write commits at E162.
- `busy` is high from the cycle after E0 through the cycle of E162: 162 M-cycles.
- One byte per M-cycle; read and write stages overlap, so throughput is 1 byte/M-cycle.
- `ce=0` freezes all state; outputs hold.

## Test plan
- **Basic transfer:** reset, then write `reg_d=8'hC1`, with source memory byte = low address byte.
  - First `src_addr=16'hC100` two `ce` edges later.
  - Byte 0 written as `oam_addr=1`, `oam_be=10`, `oam_d[15:8]=8'h00`.
  - Byte 159 written as `oam_addr=78`, `oam_be=01`, `oam_d[7:0]=8'h9F`.
  - `busy` high for exactly 162 `ce` edges.
- **Layout check:** source holds sprite 5 = {y=8'h20, x=8'h18, tile=8'h42, attrs=8'h60}.
  - Afterwards OAM word 11 = `16'h2018` and word 10 = `16'h4260`.
- **Echo fold:** write `8'hE3`; all `src_addr` lie in `16'hC300–C39F`. `reg_q` reads `8'hE3`.
- **Restart at byte 50** with page `8'hD0`:
  - Byte 50 of the old page is written during the `START` cycle.
  - Next read is `16'hD000`; 160 more writes follow.
  - `busy` stays continuously high.
- **Reset at byte 80:**
  - `src_rd`, `oam_we` and `busy` are 0 the next cycle and `reg_q=8'hFF`.
  - No writes occur until a new `reg_wr`.
- **`ce` gating:** `ce` asserted 1 in 4 clocks. Transfer completes in 162 `ce` edges, with each output stable across the 4 clocks of its M-cycle.
